// File: rtl/cpu_pkg.sv
// cpu_pkg: shared write-back encodings and WB FSM state type for the 8-bit pipelined CPU
package cpu_pkg;
  localparam logic [1:0] RDATA_SEL_MUX = 2'b00;
  localparam logic [1:0] RDATA_SEL_INP = 2'b01;
  localparam logic [1:0] RDATA_SEL_RD2 = 2'b10;
  localparam logic [1:0] RDATA_SEL_IMM = 2'b11;
  localparam logic [1:0] PCSEL_BR      = 2'b00;
  localparam logic [1:0] PCSEL_NEXT    = 2'b01;
  localparam logic [1:0] PCSEL_WB      = 2'b10;
  typedef enum logic {WB_IDLE = 1'b0, WB_IMM = 1'b1} wb_state_e;
endpackage

// File: rtl/wb_stage_ctrl_if.sv
// wb_stage_ctrl_if: MEM/WB beat inputs and writeback-stage outputs; master drives beats, slave is the WB stage
interface wb_stage_ctrl_if #(parameter int DATA_W = 8, parameter int RADDR_W = 2, parameter int CNT_W = 16);
  logic               wr_en_regf_W;
  logic               mux_out_sel_W;
  logic [1:0]         mux_rdata_sel_W;
  logic               out_port_sel_W;
  logic               rd_en_W;
  logic [RADDR_W-1:0] ADDER_W;
  logic [DATA_W-1:0]  read_data_W;
  logic [DATA_W-1:0]  alu_out_W;
  logic [DATA_W-1:0]  IN_PORT_W;
  logic [DATA_W-1:0]  instr_W;
  logic [DATA_W-1:0]  RD2_W;
  logic [1:0]         PC_Sel_W;
  logic               is_2_byte_out;
  logic               nothing_here_out;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic [DATA_W-1:0]  out_port;
  logic               out_port_stb;
  logic               pc_load;
  logic [DATA_W-1:0]  pc_value;
  logic [CNT_W-1:0]   retire_count;
  modport master (
    output wr_en_regf_W, mux_out_sel_W, mux_rdata_sel_W, out_port_sel_W, rd_en_W, ADDER_W,
           read_data_W, alu_out_W, IN_PORT_W, instr_W, RD2_W, PC_Sel_W, is_2_byte_out, nothing_here_out,
    input  rf_we, rf_waddr, rf_wdata, out_port, out_port_stb, pc_load, pc_value, retire_count
  );
  modport slave (
    input  wr_en_regf_W, mux_out_sel_W, mux_rdata_sel_W, out_port_sel_W, rd_en_W, ADDER_W,
           read_data_W, alu_out_W, IN_PORT_W, instr_W, RD2_W, PC_Sel_W, is_2_byte_out, nothing_here_out,
    output rf_we, rf_waddr, rf_wdata, out_port, out_port_stb, pc_load, pc_value, retire_count
  );
endinterface

// File: rtl/wb_stage_ctrl_imm.sv
// wb_imm_fsm: sequences opcode/immediate beats of 2-byte instructions and flags the retiring beat
module wb_imm_fsm
  import cpu_pkg::*;
#(
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  logic               is_2_byte,
  input  logic [RADDR_W-1:0] addr,
  output logic               retire,
  output logic [RADDR_W-1:0] waddr
);
  wb_state_e          state_q, state_d;
  logic [RADDR_W-1:0] pend_addr_q, pend_addr_d;
  // opcode beat of a 2-byte op parks its destination; the next valid beat completes it
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    if (valid && state_q == WB_IDLE && is_2_byte) begin
      state_d     = WB_IMM;
      pend_addr_d = addr;
    end else if (valid && state_q == WB_IMM) begin
      state_d     = WB_IDLE;
    end
  end
  assign retire = reset && valid && (state_q == WB_IMM || !is_2_byte);
  assign waddr  = state_q == WB_IMM ? pend_addr_q : addr;
  // state and pending destination, cleared asynchronously to drop any in-flight sequence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WB_IDLE;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
    end
  end
endmodule

// File: rtl/wb_stage_ctrl.sv
// wb_stage_ctrl: writeback stage - data mux, rf write port, OUT register, WB PC redirect, retire counter (WB_RETIRE_CNT_EN)
module wb_stage_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            reset,
  wb_stage_ctrl_if.slave wb
);
  logic              retire;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic              out_stb_q, out_stb_d;
  wb_imm_fsm #(.RADDR_W(RADDR_W)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .valid    (!wb.nothing_here_out),
    .is_2_byte(wb.is_2_byte_out),
    .addr     (wb.ADDER_W),
    .retire   (retire),
    .waddr    (wb.rf_waddr)
  );
  // write-back data source select
  always_comb begin
    wdata = wb.mux_rdata_sel_W == RDATA_SEL_MUX ? (wb.mux_out_sel_W ? wb.read_data_W : wb.alu_out_W) :
            wb.mux_rdata_sel_W == RDATA_SEL_INP ? wb.IN_PORT_W :
            wb.mux_rdata_sel_W == RDATA_SEL_RD2 ? wb.RD2_W : wb.instr_W;
  end
  assign wb.rf_we    = retire && wb.wr_en_regf_W;
  assign wb.rf_wdata = wdata;
  assign wb.pc_load  = retire && wb.PC_Sel_W == PCSEL_WB;
  assign wb.pc_value = wb.read_data_W;
  // OUT port loads RD2 on a retiring beat and pulses its strobe for that one update
  always_comb begin
    out_stb_d  = retire && wb.out_port_sel_W;
    out_port_d = out_stb_d ? wb.RD2_W : out_port_q;
  end
  // OUT register and strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_port_q <= '0;
      out_stb_q  <= 1'b0;
    end else begin
      out_port_q <= out_port_d;
      out_stb_q  <= out_stb_d;
    end
  end
  assign wb.out_port     = out_port_q;
  assign wb.out_port_stb = out_stb_q;
`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // one count per retiring beat, wrapping naturally
  always_comb begin
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end
  // retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign wb.retire_count = cnt_q;
`else
  assign wb.retire_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_wb_stage_ctrl.sv
// tb_wb_stage_ctrl: directed checks of wb_stage_ctrl (counter checks follow WB_RETIRE_CNT_EN)
module tb_wb_stage_ctrl;
  import cpu_pkg::*;
`ifdef WB_RETIRE_CNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  wb_stage_ctrl_if #(.DATA_W(8), .RADDR_W(2), .CNT_W(4)) w ();
  wb_stage_ctrl #(.DATA_W(8), .RADDR_W(2), .CNT_W(4)) dut (.clk(clk), .reset(reset), .wb(w));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    w.wr_en_regf_W = 0; w.mux_out_sel_W = 0; w.mux_rdata_sel_W = RDATA_SEL_MUX;
    w.out_port_sel_W = 0; w.rd_en_W = 0; w.ADDER_W = 0; w.read_data_W = 0;
    w.alu_out_W = 0; w.IN_PORT_W = 0; w.instr_W = 0; w.RD2_W = 0;
    w.PC_Sel_W = PCSEL_NEXT; w.is_2_byte_out = 0; w.nothing_here_out = 1;
  endtask

  initial begin
    clr();
    w.nothing_here_out = 0; w.wr_en_regf_W = 1; w.PC_Sel_W = PCSEL_WB; w.out_port_sel_W = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rf_we", w.rf_we, 0);
    chk("rst_pc_load", w.pc_load, 0);
    chk("rst_out_port", w.out_port, 0);
    chk("rst_stb", w.out_port_stb, 0);
    chk("rst_count", w.retire_count, 0);
    @(negedge clk); clr(); reset = 1;
    // 1-byte ALU op
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.wr_en_regf_W = 1; w.alu_out_W = 8'h5A; w.ADDER_W = 2; w.read_data_W = 8'hEE;
    #1;
    chk("alu_we", w.rf_we, 1);
    chk("alu_waddr", w.rf_waddr, 2);
    chk("alu_wdata", w.rf_wdata, 8'h5A);
    chk("alu_pc_load", w.pc_load, 0);
    @(negedge clk); clr(); #1;
    chk("alu_count", w.retire_count, EN ? 1 : 0);
    chk("bubble_we", w.rf_we, 0);
    // remaining mux sources
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.wr_en_regf_W = 1; w.mux_out_sel_W = 1; w.read_data_W = 8'hA7; w.alu_out_W = 8'h11; w.ADDER_W = 1;
    #1; chk("mem_wdata", w.rf_wdata, 8'hA7);
    w.mux_rdata_sel_W = RDATA_SEL_INP; w.IN_PORT_W = 8'h3C;
    #1; chk("inp_wdata", w.rf_wdata, 8'h3C);
    w.mux_rdata_sel_W = RDATA_SEL_RD2; w.RD2_W = 8'h96;
    #1; chk("rd2_wdata", w.rf_wdata, 8'h96);
    w.mux_rdata_sel_W = RDATA_SEL_IMM; w.instr_W = 8'h4B;
    #1; chk("imm_wdata", w.rf_wdata, 8'h4B);
    // LDM split by two bubbles
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.is_2_byte_out = 1; w.ADDER_W = 3; w.wr_en_regf_W = 1;
    w.PC_Sel_W = PCSEL_WB; w.out_port_sel_W = 1; w.RD2_W = 8'h77;
    #1;
    chk("ldmA_we", w.rf_we, 0);
    chk("ldmA_pc_load", w.pc_load, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); clr();
      w.is_2_byte_out = 1; w.wr_en_regf_W = 1; w.ADDER_W = 0; w.PC_Sel_W = PCSEL_WB;
      #1;
      chk("ldm_bubble_we", w.rf_we, 0);
      chk("ldm_bubble_stb", w.out_port_stb, 0);
    end
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.is_2_byte_out = 1; w.ADDER_W = 0; w.wr_en_regf_W = 1;
    w.mux_rdata_sel_W = RDATA_SEL_IMM; w.instr_W = 8'hC4;
    #1;
    chk("ldmB_we", w.rf_we, 1);
    chk("ldmB_waddr", w.rf_waddr, 3);
    chk("ldmB_wdata", w.rf_wdata, 8'hC4);
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.is_2_byte_out = 0; w.ADDER_W = 1; w.wr_en_regf_W = 1;
    #1;
    chk("after_ldm_we", w.rf_we, 1);
    chk("after_ldm_waddr", w.rf_waddr, 1);
    chk("ldm_no_out", w.out_port, 0);
    // OUT
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.out_port_sel_W = 1; w.RD2_W = 8'h81;
    #1;
    chk("out_we", w.rf_we, 0);
    chk("out_not_yet", w.out_port, 0);
    @(negedge clk); clr();
    w.out_port_sel_W = 1; w.RD2_W = 8'h55;
    #1;
    chk("out_port", w.out_port, 8'h81);
    chk("out_stb", w.out_port_stb, 1);
    @(negedge clk); clr(); #1;
    chk("out_hold", w.out_port, 8'h81);
    chk("out_stb_drop", w.out_port_stb, 0);
    // RET
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.PC_Sel_W = PCSEL_WB; w.read_data_W = 8'h3F;
    #1;
    chk("ret_pc_load", w.pc_load, 1);
    chk("ret_pc_value", w.pc_value, 8'h3F);
    w.PC_Sel_W = PCSEL_BR;
    #1; chk("br_pc_load", w.pc_load, 0);
    @(negedge clk); clr();
    w.PC_Sel_W = PCSEL_WB; w.read_data_W = 8'h3F;
    #1; chk("bubble_pc_load", w.pc_load, 0);
    // reset while in IMM
    @(negedge clk); clr();
    w.nothing_here_out = 0; w.is_2_byte_out = 1; w.ADDER_W = 2;
    @(negedge clk); clr();
    #2 reset = 0;
    #1;
    chk("async_out_port", w.out_port, 0);
    chk("async_count", w.retire_count, 0);
    w.nothing_here_out = 0; w.wr_en_regf_W = 1; w.PC_Sel_W = PCSEL_WB;
    #1;
    chk("rst_low_we", w.rf_we, 0);
    chk("rst_low_pc", w.pc_load, 0);
    @(negedge clk); clr(); reset = 1;
    w.nothing_here_out = 0; w.is_2_byte_out = 0; w.wr_en_regf_W = 1; w.ADDER_W = 1; w.alu_out_W = 8'h07;
    #1;
    chk("post_rst_we", w.rf_we, 1);
    chk("post_rst_waddr", w.rf_waddr, 1);
    chk("post_rst_wdata", w.rf_wdata, 8'h07);
    @(negedge clk); clr(); #1;
    chk("post_rst_out", w.out_port, 0);
    chk("post_rst_count", w.retire_count, EN ? 1 : 0);
    // counter wrap (4-bit)
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); clr();
      w.nothing_here_out = 0;
    end
    @(negedge clk); clr(); #1;
    chk("count_15", w.retire_count, EN ? 15 : 0);
    w.nothing_here_out = 0;
    @(negedge clk); clr(); #1;
    chk("count_wrap", w.retire_count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
